// File: rtl/guard_patrol.sv
// Guard patrol controller: walks a fixed loop of waypoints (X axis first, then Y),
// pauses at each one, and freezes on alert. All outputs are registered.
module guard_patrol #(
    parameter int unsigned NUM_WP       = 4,
    parameter logic [9:0]  WP0_X        = 10'd120,
    parameter logic [9:0]  WP0_Y        = 10'd300,
    parameter logic [9:0]  WP1_X        = 10'd300,
    parameter logic [9:0]  WP1_Y        = 10'd300,
    parameter logic [9:0]  WP2_X        = 10'd300,
    parameter logic [9:0]  WP2_Y        = 10'd150,
    parameter logic [9:0]  WP3_X        = 10'd120,
    parameter logic [9:0]  WP3_Y        = 10'd150,
    parameter int unsigned TOL          = 1,
    parameter int unsigned PAUSE_FRAMES = 60,
    parameter int unsigned STALL_FRAMES = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic       alert,
    input  logic [9:0] GuardX,
    input  logic [9:0] GuardY,
    output logic [2:0] direction_guard,
    output logic [1:0] wp_index,
    output logic       lap_pulse,
    output logic [2:0] state_dbg
);

    localparam int unsigned SW      = $clog2(STALL_FRAMES + 1);
    localparam int unsigned PW      = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam logic [10:0] TOL_W   = 11'(TOL);
    localparam logic [1:0]  LAST_WP = 2'(NUM_WP - 1);

    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_RIGHT = 3'b001;
    localparam logic [2:0] DIR_DOWN  = 3'b010;
    localparam logic [2:0] DIR_UP    = 3'b011;
    localparam logic [2:0] DIR_STOP  = 3'b100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVE_X = 3'd1,
        MOVE_Y = 3'd2,
        PAUSE  = 3'd3,
        HALT   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    dir_q, dir_d;
    logic [1:0]    wp_q, wp_d;
    logic          lap_q, lap_d;
    logic [PW-1:0] pause_q, pause_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [9:0]    prev_x_q, prev_y_q;

    logic [9:0]  tx, ty;
    logic [10:0] gx_w, gy_w, tx_w, ty_w;
    logic        x_lo, x_hi, y_lo, y_hi, x_same, y_same, stall_full;
    logic [2:0]  x_dir;

    // Current target waypoint
    always_comb begin
        tx = WP0_X;
        ty = WP0_Y;
        case (wp_q)
            2'd0: begin tx = WP0_X; ty = WP0_Y; end
            2'd1: begin tx = WP1_X; ty = WP1_Y; end
            2'd2: begin tx = WP2_X; ty = WP2_Y; end
            2'd3: begin tx = WP3_X; ty = WP3_Y; end
            default: begin tx = WP0_X; ty = WP0_Y; end
        endcase
    end

    // Tolerance windows are evaluated in 11 bits so the +TOL terms never wrap
    always_comb begin
        gx_w       = {1'b0, GuardX};
        gy_w       = {1'b0, GuardY};
        tx_w       = {1'b0, tx};
        ty_w       = {1'b0, ty};
        x_lo       = (gx_w + TOL_W) < tx_w;
        x_hi       = gx_w > (tx_w + TOL_W);
        y_lo       = (gy_w + TOL_W) < ty_w;
        y_hi       = gy_w > (ty_w + TOL_W);
        x_same     = (GuardX == prev_x_q);
        y_same     = (GuardY == prev_y_q);
        stall_full = (stall_q >= SW'(STALL_FRAMES));
        x_dir      = x_lo ? DIR_RIGHT : (x_hi ? DIR_LEFT : DIR_STOP);
    end

    always_comb begin
        state_d = state_q;
        dir_d   = DIR_STOP;
        wp_d    = wp_q;
        lap_d   = 1'b0;
        pause_d = pause_q;
        stall_d = '0;
        if (alert && (state_q != IDLE)) begin
            state_d = HALT;
            pause_d = '0;
        end else if (!enable) begin
            state_d = IDLE;
            pause_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!alert) state_d = MOVE_X;
                end
                MOVE_X: begin
                    if (stall_full || (!x_lo && !x_hi)) begin
                        state_d = MOVE_Y;
                    end else begin
                        dir_d   = x_dir;
                        stall_d = x_same ? (stall_q + SW'(1)) : '0;
                    end
                end
                MOVE_Y: begin
                    if (stall_full || (!y_lo && !y_hi)) begin
                        state_d = PAUSE;
                        pause_d = PW'(PAUSE_FRAMES - 1);
                    end else begin
                        dir_d   = y_lo ? DIR_DOWN : DIR_UP;
                        stall_d = y_same ? (stall_q + SW'(1)) : '0;
                    end
                end
                PAUSE: begin
                    if (pause_q == '0) begin
                        state_d = MOVE_X;
                        if (wp_q == LAST_WP) begin
                            wp_d  = 2'd0;
                            lap_d = 1'b1;
                        end else begin
                            wp_d = wp_q + 2'd1;
                        end
                    end else begin
                        pause_d = pause_q - PW'(1);
                    end
                end
                // Resume heads straight back toward the held waypoint
                HALT: begin
                    state_d = MOVE_X;
                    pause_d = '0;
                    dir_d   = x_dir;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_STOP;
            wp_q    <= 2'd0;
            lap_q   <= 1'b0;
            pause_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            wp_q    <= wp_d;
            lap_q   <= lap_d;
            pause_q <= pause_d;
            stall_q <= stall_d;
        end
        prev_x_q <= GuardX;
        prev_y_q <= GuardY;
    end

    assign direction_guard = dir_q;
    assign wp_index        = wp_q;
    assign lap_pulse       = lap_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_guard_patrol.sv
// Randomized and directed bench for guard_patrol against a cycle-level behavioural model.
module tb_guard_patrol;

    localparam int PAUSE_N = 60;
    localparam int STALL_N = 8;
    localparam int TOL_N   = 1;

    logic       frame_clk = 1'b0;
    logic       Reset, enable, alert;
    logic [9:0] GuardX, GuardY;
    logic [2:0] direction_guard;
    logic [1:0] wp_index;
    logic       lap_pulse;
    logic [2:0] state_dbg;

    guard_patrol dut (
        .frame_clk       (frame_clk),
        .Reset           (Reset),
        .enable          (enable),
        .alert           (alert),
        .GuardX          (GuardX),
        .GuardY          (GuardY),
        .direction_guard (direction_guard),
        .wp_index        (wp_index),
        .lap_pulse       (lap_pulse),
        .state_dbg       (state_dbg)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int errors = 0;
    int wx[4] = '{120, 300, 300, 120};
    int wy[4] = '{300, 300, 150, 150};

    // Reference model: state numbers 0 idle, 1 move-x, 2 move-y, 3 pause, 4 halt
    int m_state = 0, m_dir = 4, m_wp = 0, m_lap = 0;
    int m_pause = 0, m_stall = 0, m_prevx = 0, m_prevy = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int gx, gy, tx, ty, nstall;
        gx = int'(GuardX);
        gy = int'(GuardY);
        tx = wx[m_wp];
        ty = wy[m_wp];
        m_lap  = 0;
        m_dir  = 4;
        nstall = 0;
        if (Reset) begin
            m_state = 0; m_wp = 0; m_pause = 0;
        end else if (alert && m_state != 0) begin
            m_state = 4; m_pause = 0;
        end else if (!enable) begin
            m_state = 0; m_pause = 0;
        end else begin
            case (m_state)
                0: if (!alert) m_state = 1;
                1: begin
                    if (m_stall >= STALL_N || (gx + TOL_N >= tx && gx <= tx + TOL_N)) m_state = 2;
                    else begin
                        m_dir  = (gx + TOL_N < tx) ? 1 : 0;
                        nstall = (gx == m_prevx) ? m_stall + 1 : 0;
                    end
                end
                2: begin
                    if (m_stall >= STALL_N || (gy + TOL_N >= ty && gy <= ty + TOL_N)) begin
                        m_state = 3; m_pause = PAUSE_N - 1;
                    end else begin
                        m_dir  = (gy + TOL_N < ty) ? 2 : 3;
                        nstall = (gy == m_prevy) ? m_stall + 1 : 0;
                    end
                end
                3: begin
                    if (m_pause == 0) begin
                        m_wp    = (m_wp + 1) % 4;
                        m_lap   = (m_wp == 0) ? 1 : 0;
                        m_state = 1;
                    end else m_pause--;
                end
                default: begin
                    m_state = 1; m_pause = 0;
                    m_dir = (gx + TOL_N < tx) ? 1 : ((gx > tx + TOL_N) ? 0 : 4);
                end
            endcase
        end
        m_stall = nstall;
        m_prevx = gx;
        m_prevy = gy;
    endtask

    task automatic cycle();
        model_step();
        @(posedge frame_clk);
        #1;
        check("direction", 32'(direction_guard), 32'(m_dir));
        check("wp_index",  32'(wp_index),        32'(m_wp));
        check("lap_pulse", 32'(lap_pulse),       32'(m_lap));
        check("state",     32'(state_dbg),       32'(m_state));
    endtask

    initial begin
        int npause, n001, nlap, r, d;
        bit found;
        Reset = 1'b1; enable = 1'b1; alert = 1'b1; GuardX = 10'd120; GuardY = 10'd300;
        repeat (3) begin
            cycle();
            check("rst_dir", 32'(direction_guard), 32'd4);
            check("rst_wp",  32'(wp_index),        32'd0);
        end

        // Already at wp0: pass through both axes, then pause
        Reset = 1'b0; alert = 1'b0; npause = 0;
        repeat (66) begin
            cycle();
            if (state_dbg == 3'd3) npause++;
        end
        check("pause_len", 32'(npause), 32'(PAUSE_N));
        check("wp_after_pause", 32'(wp_index), 32'd1);
        check("dir_toward_wp1", 32'(direction_guard), 32'd1);

        // Alert mid-move, then resume
        alert = 1'b1;
        cycle();
        check("alert_halt", 32'(state_dbg), 32'd4);
        repeat (4) cycle();
        alert = 1'b0;
        cycle();
        check("resume_state", 32'(state_dbg), 32'd1);
        check("resume_dir", 32'(direction_guard), 32'd1);
        repeat (2) cycle();

        // Frozen X counts as arrival after the stall window
        GuardX = 10'd200; n001 = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (state_dbg == 3'd2) found = 1'b1;
            else if (direction_guard == 3'd1) n001++;
        end
        check("stall_arrive", 32'(found), 32'd1);
        check("stall_dir_cycles", 32'(n001 >= STALL_N), 32'd1);

        // Halt discards the pause and retargets wp1; ramp X into tolerance
        repeat (3) cycle();
        alert = 1'b1;
        repeat (2) cycle();
        alert = 1'b0; GuardX = 10'd150; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            cycle();
            if (state_dbg == 3'd2) found = 1'b1;
            else GuardX = GuardX + 10'd1;
        end
        check("ramp_arrive", 32'(found), 32'd1);
        check("ramp_end_x", 32'(GuardX), 32'd299);
        repeat (3) begin
            cycle();
            check("ramp_y_stop", 32'(direction_guard), 32'd4);
        end

        // Visit remaining waypoints until the lap wraps
        found = 1'b0; nlap = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            GuardX = 10'(wx[m_wp]); GuardY = 10'(wy[m_wp]);
            cycle();
            if (lap_pulse) begin found = 1'b1; nlap++; end
        end
        check("lap_seen", 32'(found), 32'd1);
        GuardX = 10'd100; GuardY = 10'd300;
        repeat (3) begin
            cycle();
            if (lap_pulse) nlap++;
        end
        check("lap_once", 32'(nlap), 32'd1);
        check("wrap_wp", 32'(wp_index), 32'd0);
        check("wrap_dir", 32'(direction_guard), 32'd1);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            Reset  = ($urandom_range(0, 249) == 0);
            enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 49) == 0) alert = ~alert;
            r = int'($urandom_range(0, 9));
            d = int'($urandom_range(1, 5));
            if (r < 6) begin
                if (int'(GuardX) < wx[m_wp]) GuardX = 10'(int'(GuardX) + d);
                else if (int'(GuardX) > wx[m_wp]) GuardX = 10'(int'(GuardX) - d);
                else if (int'(GuardY) < wy[m_wp]) GuardY = 10'(int'(GuardY) + d);
                else if (int'(GuardY) > wy[m_wp]) GuardY = 10'(int'(GuardY) - d);
            end else if (r == 8) begin
                GuardX = 10'($urandom_range(0, 1023));
                GuardY = 10'($urandom_range(0, 1023));
            end else if (r == 9) begin
                GuardX = 10'(wx[m_wp]); GuardY = 10'(wy[m_wp]);
            end
            cycle();
            check("dir_legal", 32'(direction_guard <= 3'd4), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
